// File: rtl/match_tracker.sv
// match_tracker: registers x==y per accepted pair, then tracks match/mismatch runs to lock/unlock.
// Optional build macro MATCH_TRACKER_STATS_EN enables the saturating mismatch_total counter.
module match_tracker #(
  parameter int N          = 3,
  parameter int LOCK_CNT   = 4,
  parameter int MISS_CNT   = 2,
  parameter int RESYNC_CYC = 3,
  parameter int CNT_W      = 16
) (
  input  logic                          clock,
  input  logic                          n_reset,
  input  logic [N-1:0]                  x,
  input  logic [N-1:0]                  y,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          locked,
  output logic [$clog2(LOCK_CNT+1)-1:0] match_run,
  output logic                          lock_event,
  output logic                          lost_event,
  output logic [CNT_W-1:0]              mismatch_total
);

  localparam int RUN_W   = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(MISS_CNT + 1);
  localparam int TIMER_W = $clog2(RESYNC_CYC + 1);

  localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(MISS_CNT - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RESYNC_CYC - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_LOCKED = 2'd1,
    ST_RESYNC = 2'd2
  } state_e;

  state_e              state_q;
  logic [RUN_W-1:0]    match_run_q;
  logic [MISS_W-1:0]   miss_run_q;
  logic [TIMER_W-1:0]  timer_q;
  logic                locked_q;
  logic                lock_event_q;
  logic                lost_event_q;

  logic                eq_q;
  logic                eq_v_q;
  logic [N-1:0]        bit_eq;
  logic                sample_eq;
  logic                accept;
  logic                consume;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit_eq
      assign bit_eq[gi] = ~(x[gi] ^ y[gi]);
    end
  endgenerate

  assign sample_eq = &bit_eq;
  assign in_ready  = (state_q != ST_RESYNC);
  assign accept    = in_valid && in_ready;
  // A result landing while resyncing is dropped, so it never reaches counters or stats.
  assign consume   = eq_v_q && (state_q != ST_RESYNC);

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      eq_q   <= 1'b0;
      eq_v_q <= 1'b0;
    end else begin
      eq_v_q <= accept;
      if (accept) begin
        eq_q <= sample_eq;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q      <= ST_SEARCH;
      match_run_q  <= '0;
      miss_run_q   <= '0;
      timer_q      <= '0;
      locked_q     <= 1'b0;
      lock_event_q <= 1'b0;
      lost_event_q <= 1'b0;
    end else begin
      lock_event_q <= 1'b0;
      lost_event_q <= 1'b0;
      unique case (state_q)
        ST_SEARCH: begin
          if (consume) begin
            if (!eq_q) begin
              match_run_q <= '0;
            end else if (match_run_q == RUN_LAST) begin
              state_q      <= ST_LOCKED;
              match_run_q  <= '0;
              miss_run_q   <= '0;
              locked_q     <= 1'b1;
              lock_event_q <= 1'b1;
            end else begin
              match_run_q <= match_run_q + 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (consume) begin
            if (eq_q) begin
              miss_run_q <= '0;
            end else if (miss_run_q == MISS_LAST) begin
              state_q      <= ST_RESYNC;
              miss_run_q   <= '0;
              timer_q      <= '0;
              locked_q     <= 1'b0;
              lost_event_q <= 1'b1;
            end else begin
              miss_run_q <= miss_run_q + 1'b1;
            end
          end
        end
        ST_RESYNC: begin
          if (timer_q == TIMER_LAST) begin
            state_q <= ST_SEARCH;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= ST_SEARCH;
      endcase
    end
  end

  assign locked     = locked_q;
  assign match_run  = match_run_q;
  assign lock_event = lock_event_q;
  assign lost_event = lost_event_q;

`ifdef MATCH_TRACKER_STATS_EN
  logic [CNT_W-1:0] mismatch_total_q;
  logic [CNT_W-1:0] mismatch_total_d;

  always_comb begin
    mismatch_total_d = mismatch_total_q;
    if (consume && !eq_q && (mismatch_total_q != {CNT_W{1'b1}})) begin
      mismatch_total_d = mismatch_total_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      mismatch_total_q <= '0;
    end else begin
      mismatch_total_q <= mismatch_total_d;
    end
  end

  assign mismatch_total = mismatch_total_q;
`else
  assign mismatch_total = '0;
`endif

endmodule

// File: tb/tb_match_tracker.sv
// Scoreboard bench for match_tracker: a run-history reference model queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_match_tracker;

  localparam int N          = 3;
  localparam int LOCK_CNT   = 4;
  localparam int MISS_CNT   = 2;
  localparam int RESYNC_CYC = 3;
  localparam int CNT_W      = 2;
  localparam int RUN_W      = $clog2(LOCK_CNT + 1);

  logic             clock = 1'b0;
  logic             n_reset;
  logic [N-1:0]     x;
  logic [N-1:0]     y;
  logic             in_valid;
  logic             in_ready;
  logic             locked;
  logic [RUN_W-1:0] match_run;
  logic             lock_event;
  logic             lost_event;
  logic [CNT_W-1:0] mismatch_total;

  always #5 clock = ~clock;

  match_tracker #(
    .N(N), .LOCK_CNT(LOCK_CNT), .MISS_CNT(MISS_CNT),
    .RESYNC_CYC(RESYNC_CYC), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .n_reset(n_reset), .x(x), .y(y), .in_valid(in_valid),
    .in_ready(in_ready), .locked(locked), .match_run(match_run),
    .lock_event(lock_event), .lost_event(lost_event), .mismatch_total(mismatch_total)
  );

  typedef struct {
    bit rdy;
    bit lck;
    int run;
    bit lev;
    bit lost;
    int total;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: mode plus trailing-run counts, remaining stall cycles, one in-flight sample.
  typedef enum int {M_SEARCH, M_LOCKED, M_RESYNC} mmode_e;
  mmode_e m_mode = M_SEARCH;
  int     m_run = 0, m_miss = 0, m_stall = 0, m_total = 0;
  bit     m_pend_v = 0, m_pend_eq = 0, m_lev = 0, m_lost = 0;

  task automatic model_step();
    bit ready_before;
    m_lev = 0;
    m_lost = 0;
    if (!n_reset) begin
      m_mode = M_SEARCH; m_run = 0; m_miss = 0; m_stall = 0; m_total = 0;
      m_pend_v = 0; m_pend_eq = 0;
      return;
    end
    ready_before = (m_mode != M_RESYNC);
    if (m_mode == M_RESYNC) begin
      m_stall--;
      if (m_stall == 0) m_mode = M_SEARCH;
    end else if (m_pend_v) begin
`ifdef MATCH_TRACKER_STATS_EN
      if (!m_pend_eq && m_total < (1 << CNT_W) - 1) m_total++;
`endif
      if (m_mode == M_SEARCH) begin
        m_run = m_pend_eq ? m_run + 1 : 0;
        if (m_run == LOCK_CNT) begin
          m_mode = M_LOCKED; m_run = 0; m_miss = 0; m_lev = 1;
        end
      end else begin
        m_miss = m_pend_eq ? 0 : m_miss + 1;
        if (m_miss == MISS_CNT) begin
          m_mode = M_RESYNC; m_miss = 0; m_stall = RESYNC_CYC; m_lost = 1;
        end
      end
    end
    m_pend_v  = in_valid && ready_before;
    m_pend_eq = (x == y);
  endtask

  task automatic cycle(input bit rst_n, input bit v, input logic [N-1:0] xa, input logic [N-1:0] ya);
    exp_t e;
    n_reset  = rst_n;
    in_valid = v;
    x        = xa;
    y        = ya;
    @(posedge clock);
    model_step();
    e.rdy = (m_mode != M_RESYNC);
    e.lck = (m_mode == M_LOCKED);
    e.run = m_run;
    e.lev = m_lev;
    e.lost = m_lost;
    e.total = m_total;
    exp_q.push_back(e);
    #2;
  endtask

  task automatic send(input bit v, input bit match);
    logic [N-1:0] a, d;
    a = N'($urandom);
    d = N'($urandom_range(1, (1 << N) - 1));
    cycle(1'b1, v, a, match ? a : a ^ d);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cyc++;
        $display("cyc %0d rdy=%0b locked=%0b run=%0d lock_ev=%0b lost_ev=%0b total=%0d",
                 cyc, in_ready, locked, match_run, lock_event, lost_event, mismatch_total);
        chk("in_ready",       32'(in_ready),       32'(e.rdy));
        chk("locked",         32'(locked),         32'(e.lck));
        chk("match_run",      32'(match_run),      32'(e.run));
        chk("lock_event",     32'(lock_event),     32'(e.lev));
        chk("lost_event",     32'(lost_event),     32'(e.lost));
        chk("mismatch_total", 32'(mismatch_total), 32'(e.total));
      end
    end
  end

  initial begin : stimulus
    int pm;
    n_reset = 1'b0; in_valid = 1'b1; x = 3'b101; y = 3'b101;
    // Reset held two cycles with valid high.
    repeat (2) cycle(1'b0, 1'b1, 3'b101, 3'b101);
    // Back-to-back lock.
    repeat (4) cycle(1'b1, 1'b1, 3'b101, 3'b101);
    repeat (3) cycle(1'b1, 1'b0, 3'b000, 3'b000);
    // Lose lock with valid held high through the stall.
    repeat (2) cycle(1'b1, 1'b1, 3'b001, 3'b011);
    repeat (6) cycle(1'b1, 1'b1, 3'b110, 3'b110);
    repeat (2) cycle(1'b1, 1'b1, 3'b001, 3'b011);
    repeat (5) cycle(1'b1, 1'b0, 3'b000, 3'b000);
    // Broken run: 3 matches, 1 mismatch, 4 matches.
    repeat (3) cycle(1'b1, 1'b1, 3'b101, 3'b101);
    cycle(1'b1, 1'b1, 3'b001, 3'b011);
    repeat (4) cycle(1'b1, 1'b1, 3'b101, 3'b101);
    repeat (3) cycle(1'b1, 1'b0, 3'b000, 3'b000);
    repeat (2) cycle(1'b1, 1'b1, 3'b001, 3'b011);
    repeat (4) cycle(1'b1, 1'b0, 3'b000, 3'b000);
    // Bubbles between matches, then a mid-run reset.
    repeat (4) begin
      cycle(1'b1, 1'b1, 3'b011, 3'b011);
      cycle(1'b1, 1'b0, 3'b000, 3'b111);
    end
    repeat (2) cycle(1'b1, 1'b1, 3'b001, 3'b011);
    repeat (4) cycle(1'b1, 1'b0, 3'b000, 3'b000);
    repeat (2) cycle(1'b1, 1'b1, 3'b111, 3'b111);
    repeat (2) cycle(1'b1, 1'b0, 3'b000, 3'b000);
    cycle(1'b0, 1'b1, 3'b111, 3'b111);
    repeat (3) cycle(1'b1, 1'b0, 3'b000, 3'b000);
    // Five mismatches in SEARCH exercise stats saturation.
    repeat (5) cycle(1'b1, 1'b1, 3'b100, 3'b000);
    repeat (2) cycle(1'b1, 1'b0, 3'b000, 3'b000);
    cycle(1'b0, 1'b0, 3'b000, 3'b000);
    // Randomized phases with varying match density.
    for (int ph = 0; ph < 15; ph++) begin
      pm = (ph % 3 == 0) ? 92 : ((ph % 3 == 1) ? 75 : 50);
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 199) == 0)
          cycle(1'b0, 1'($urandom_range(0, 1)), N'($urandom), N'($urandom));
        else
          send($urandom_range(0, 99) < 80, $urandom_range(0, 99) < pm);
      end
    end
    cycle(1'b1, 1'b0, 3'b000, 3'b000);
    @(negedge clock);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
